mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, maximum consecutive transfers by one requester before forced handoff to a pending peer (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 req0  input  1  requester 0 (CPU) transfer request; held high while transfers are wanted.
REQ-005 addr0  input  8  requester 0 memory address.
REQ-006 we0  input  1  requester 0 write enable (1 = write, 0 = read).
REQ-007 wdata0  input  8  requester 0 write data.
REQ-008 req1, addr1, we1, wdata1  input  1/8/1/8  requester 1 (loader/debug) equivalents of REQ-004..007.
REQ-009 gnt0, gnt1  output  1 each  registered grant; at most one high in any cycle.
REQ-010 mem_addr  output  8  shared memory address.
REQ-011 mem_we  output  1  shared memory write enable.
REQ-012 mem_wdata  output  8  shared memory write data.
REQ-013 mem_rdata  input  8  combinational read data from memory for current mem_addr.
REQ-014 rdata  output  8  registered read data returned to the requester.
REQ-015 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata valid for requester 0/1.

Function
REQ-016 FSM states IDLE, GRANT0, GRANT1; gnt0 = (state==GRANT0), gnt1 = (state==GRANT1).
REQ-017 Transfer for requester x occurs in any cycle with gntx && reqx; memory ports driven combinationally from that requester's addr/we/wdata.
REQ-018 With no transfer in progress, mem_addr = 0x00, mem_we = 0, mem_wdata = 0x00; mem_we never high without a transfer.
REQ-019 Grant latency: request sampled high in IDLE at edge N yields grant during cycle N+1; first transfer in cycle N+1.
REQ-020 Read transfer in cycle N: rdata <= mem_rdata and rvalidx <= 1 at edge ending N; otherwise rvalid0/1 <= 0 and rdata holds.
REQ-021 Write transfer: no rvalid pulse; rdata unchanged.
REQ-022 4-bit burst counter increments per transfer; cleared on grant change, on entering IDLE, and on reaching MAX_BURST.
REQ-023 GRANTx, reqx low: next state = GRANTy if reqy high, else IDLE (no transfer that cycle).
REQ-024 GRANTx, transfer is the MAX_BURST-th and reqy high: next state GRANTy (zero-bubble handoff).
REQ-025 GRANTx, MAX_BURST reached and reqy low: remain GRANTx, counter cleared.
REQ-026 IDLE, both requests high: winner per REQ-030/031.
REQ-027 Requester may change addr/we/wdata every cycle while granted; each granted cycle is an independent transfer.

Reset
REQ-028 On rst: state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0x00, burst counter 0, last-served = 1.
REQ-029 rst asserted mid-burst aborts at that edge; the transfer presented in that cycle (including its rvalid pulse) is discarded; no write enabled in the cycle after.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE granted to requester not last served; last-served updated on each grant; first contest after reset goes to requester 0.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins in IDLE; MAX_BURST handoff (REQ-024) still applies, bounding requester 1 starvation.

Verification
REQ-032 Reset: rst=1 two cycles with req0=req1=1 -> gnt0=gnt1=0, rvalid0/1=0, mem_we=0, rdata=0x00.
REQ-033 Single read: req0=1, addr0=0x05, mem_rdata=0xA5 -> gnt0 next cycle, mem_addr=0x05, then rdata=0xA5 with rvalid0=1 for one cycle.
REQ-034 Write: req1=1, we1=1, addr1=0x10, wdata1=0x3C -> gnt1 next cycle, mem_we=1, mem_addr=0x10, mem_wdata=0x3C for one cycle, no rvalid1.
REQ-035 Burst handoff, MAX_BURST=4: req0 and req1 held high -> exactly 4 gnt0 transfers then gnt1 on next cycle, no idle cycle; gnt0/gnt1 never both high.
REQ-036 Contest: both request from IDLE twice -> with MEM_ARB_ROUND_ROBIN_EN winners 0 then 1; without it 0 then 0.
REQ-037 Mid-burst reset: rst=1 during 2nd transfer of a gnt0 read burst -> next cycle gnt0=0, rvalid0=0, mem_we=0; regrant only after rst low plus one cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with burst-limited grants and registered read return.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contests in IDLE; default is fixed priority to requester 0.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic       we0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic       we1,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] rdata,
  output logic       rvalid0,
  output logic       rvalid1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     r_state;
  logic       r_gnt0;
  logic       r_gnt1;
  logic [3:0] r_burst;
  logic [7:0] r_rdata;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic       w_xfer0;
  logic       w_xfer1;
  logic       w_rd0;
  logic       w_rd1;
  logic       w_burst_last;
  logic       w_pick1;

  assign w_xfer0      = r_gnt0 && req0;
  assign w_xfer1      = r_gnt1 && req1;
  assign w_rd0        = w_xfer0 && !we0;
  assign w_rd1        = w_xfer1 && !we1;
  assign w_burst_last = (r_burst == BURST_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Tracks the most recently granted requester; 1 after reset so the first contest goes to 0.
  logic r_last1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last1 <= 1'b1;
    end else if (r_gnt0) begin
      r_last1 <= 1'b0;
    end else if (r_gnt1) begin
      r_last1 <= 1'b1;
    end
  end

  assign w_pick1 = !r_last1;
`else
  assign w_pick1 = 1'b0;
`endif

  // NOTE: every output is assigned a default first so no path through this block leaves a latch.
  always_comb begin
    mem_addr  = 8'h00;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (w_xfer0) begin
      mem_addr  = addr0;
      mem_we    = we0;
      mem_wdata = wdata0;
    end else if (w_xfer1) begin
      mem_addr  = addr1;
      mem_we    = we1;
      mem_wdata = wdata1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_burst   <= 4'd0;
      r_rdata   <= 8'h00;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0 || w_rd1) begin
        r_rdata <= mem_rdata;
      end

      case (r_state)
        IDLE: begin
          r_burst <= 4'd0;
          if (req0 && !(req1 && w_pick1)) begin
            r_state <= GRANT0;
            r_gnt0  <= 1'b1;
            r_gnt1  <= 1'b0;
          end else if (req1) begin
            r_state <= GRANT1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b1;
          end
        end

        GRANT0: begin
          if (!req0) begin
            r_burst <= 4'd0;
            if (req1) begin
              r_state <= GRANT1;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
            end
          end else if (w_burst_last) begin
            // Burst limit reached: hand off if the peer waits, otherwise start a fresh burst.
            r_burst <= 4'd0;
            if (req1) begin
              r_state <= GRANT1;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b1;
            end
          end else begin
            r_burst <= r_burst + 4'd1;
          end
        end

        GRANT1: begin
          if (!req1) begin
            r_burst <= 4'd0;
            if (req0) begin
              r_state <= GRANT0;
              r_gnt0  <= 1'b1;
              r_gnt1  <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
            end
          end else if (w_burst_last) begin
            r_burst <= 4'd0;
            if (req0) begin
              r_state <= GRANT0;
              r_gnt0  <= 1'b1;
              r_gnt1  <= 1'b0;
            end
          end else begin
            r_burst <= r_burst + 4'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_burst <= 4'd0;
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rdata   = r_rdata;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for basic transfers, hand sequences for
// burst handoff, burst renewal, IDLE contests and mid-burst reset.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1, mem_rdata;
  logic       gnt0, gnt1, mem_we, rvalid0, rvalid1;
  logic [7:0] mem_addr, mem_wdata, rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .addr0     (addr0),
    .we0       (we0),
    .wdata0    (wdata0),
    .req1      (req1),
    .addr1     (addr1),
    .we1       (we1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       req0;
    logic [7:0] addr0;
    logic       we0;
    logic [7:0] wdata0;
    logic       req1;
    logic [7:0] addr1;
    logic       we1;
    logic [7:0] wdata1;
    logic [7:0] mrd;
    logic       e_gnt0;
    logic       e_gnt1;
    logic [7:0] e_maddr;
    logic       e_mwe;
    logic [7:0] e_mwdata;
    logic [7:0] e_rdata;
    logic       e_rv0;
    logic       e_rv1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    req0 = 1'b0; addr0 = 8'h00; we0 = 1'b0; wdata0 = 8'h00;
    req1 = 1'b0; addr1 = 8'h00; we1 = 1'b0; wdata1 = 8'h00;
    mem_rdata = 8'h00;
  endtask

  initial begin
    // Each row: inputs for one cycle, then the outputs expected during that cycle (before its edge).
    //           rst req0 addr0  we0 wdata0 req1 addr1  we1 wdata1 mrd    gnt0 gnt1 maddr  mwe mwdata rdata  rv0 rv1
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      req0 = vecs[i].req0; addr0 = vecs[i].addr0; we0 = vecs[i].we0; wdata0 = vecs[i].wdata0;
      req1 = vecs[i].req1; addr1 = vecs[i].addr1; we1 = vecs[i].we1; wdata1 = vecs[i].wdata1;
      mem_rdata = vecs[i].mrd;
      #1;
      check($sformatf("v%0d gnt0", i),      {7'd0, gnt0},    {7'd0, vecs[i].e_gnt0});
      check($sformatf("v%0d gnt1", i),      {7'd0, gnt1},    {7'd0, vecs[i].e_gnt1});
      check($sformatf("v%0d mem_addr", i),  mem_addr,        vecs[i].e_maddr);
      check($sformatf("v%0d mem_we", i),    {7'd0, mem_we},  {7'd0, vecs[i].e_mwe});
      check($sformatf("v%0d mem_wdata", i), mem_wdata,       vecs[i].e_mwdata);
      check($sformatf("v%0d rdata", i),     rdata,           vecs[i].e_rdata);
      check($sformatf("v%0d rvalid0", i),   {7'd0, rvalid0}, {7'd0, vecs[i].e_rv0});
      check($sformatf("v%0d rvalid1", i),   {7'd0, rvalid1}, {7'd0, vecs[i].e_rv1});
      tick();
    end

    // Burst handoff: both held high from IDLE -> four gnt0 transfers, then gnt1 with no gap.
    idle_inputs();
    req0 = 1'b1; addr0 = 8'h40; req1 = 1'b1; addr1 = 8'h80;
    tick();
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("burst c%0d gnt0", c), {7'd0, gnt0}, {7'd0, (c < 4)});
      check($sformatf("burst c%0d gnt1", c), {7'd0, gnt1}, {7'd0, (c >= 4)});
      check($sformatf("burst c%0d one_hot", c), {7'd0, (gnt0 && gnt1)}, 8'h00);
      check($sformatf("burst c%0d mem_addr", c), mem_addr, (c < 4) ? 8'h40 : 8'h80);
      tick();
    end
    idle_inputs();
    tick();
    #1;
    check("burst end idle gnt1", {7'd0, gnt1}, 8'h00);
    tick();

    // Burst limit with no waiting peer: requester 0 keeps the grant across the limit.
    req0 = 1'b1; addr0 = 8'h11; we0 = 1'b1; wdata0 = 8'hC3;
    tick();
    for (int c = 0; c < 7; c++) begin
      #1;
      check($sformatf("solo c%0d gnt0", c), {7'd0, gnt0}, 8'h01);
      check($sformatf("solo c%0d mem_we", c), {7'd0, mem_we}, 8'h01);
      check($sformatf("solo c%0d rvalid0", c), {7'd0, rvalid0}, 8'h00);
      tick();
    end
    idle_inputs();
    tick();

    // IDLE contests right after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("contest1 gnt0", {7'd0, gnt0}, 8'h01);
    check("contest1 gnt1", {7'd0, gnt1}, 8'h00);
    tick();
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("contest gap gnt0", {7'd0, gnt0}, 8'h00);
    check("contest gap gnt1", {7'd0, gnt1}, 8'h00);
    tick();
    idle_inputs();
    #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("contest2 gnt0", {7'd0, gnt0}, 8'h00);
    check("contest2 gnt1", {7'd0, gnt1}, 8'h01);
`else
    check("contest2 gnt0", {7'd0, gnt0}, 8'h01);
    check("contest2 gnt1", {7'd0, gnt1}, 8'h00);
`endif
    tick();
    tick();

    // Mid-burst reset on the second read of a gnt0 burst.
    req0 = 1'b1; addr0 = 8'h07; mem_rdata = 8'h77;
    tick();
    #1;
    check("mrst xfer1 gnt0", {7'd0, gnt0}, 8'h01);
    tick();
    addr0 = 8'h08; mem_rdata = 8'h99; rst = 1'b1;
    #1;
    check("mrst xfer2 rvalid0", {7'd0, rvalid0}, 8'h01);
    check("mrst xfer2 rdata", rdata, 8'h77);
    check("mrst xfer2 mem_addr", mem_addr, 8'h08);
    tick();
    rst = 1'b0;
    #1;
    check("mrst after gnt0", {7'd0, gnt0}, 8'h00);
    check("mrst after rvalid0", {7'd0, rvalid0}, 8'h00);
    check("mrst after mem_we", {7'd0, mem_we}, 8'h00);
    check("mrst after rdata", rdata, 8'h00);
    tick();
    #1;
    check("mrst regrant gnt0", {7'd0, gnt0}, 8'h01);
    check("mrst regrant mem_addr", mem_addr, 8'h08);
    idle_inputs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
